// File: rtl/uart_tx_framer_if.sv
// rtl/uart_tx_framer_if.sv - word/config handshake bundle between TX source and uart_tx_framer
interface uart_tx_framer_if #(
    parameter int DATA_W = 9,
    parameter int DIV_W  = 16
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DIV_W-1:0]  baud_div;
    logic [3:0]        data_len;
    logic [1:0]        parity_type;
    logic              stop_bits;

    modport master (
        output tx_data, tx_valid, baud_div, data_len, parity_type, stop_bits,
        input  tx_ready
    );

    modport slave (
        input  tx_data, tx_valid, baud_div, data_len, parity_type, stop_bits,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART TX framer/serializer; define UART_TX_BREAK_EN for the send_break line-break feature
module uart_tx_framer #(
    parameter int DATA_W = 9,
    parameter int DIV_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_framer_if.slave  bus,
    output logic             tx_out,
    output logic             busy,
    output logic             frame_done
`ifdef UART_TX_BREAK_EN
    ,
    input  logic             send_break
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4
`ifdef UART_TX_BREAK_EN
        ,
        S_BRK     = 3'd5,
        S_BRK_END = 3'd6
`endif
    } state_t;

    localparam logic [3:0]       MIN_LEN = 4'd5;
    localparam logic [3:0]       MAX_LEN = 4'(DATA_W);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              tx_out_q, tx_out_d;
    logic              ready_q, ready_d;

    logic [3:0]        len_q;
    logic [DIV_W-1:0]  div_q;
    logic              par_en_q;
    logic              par_q;
    logic              stop2_q;

    logic [3:0]        len_clamp;
    logic [DIV_W-1:0]  div_clamp;
    logic [DATA_W-1:0] masked;
    logic              data_xor;
    logic              accept;
    logic              bit_end;
    logic              brk_entry;

    // Per-frame configuration as seen on the accept edge
    always_comb begin
        if (bus.data_len < MIN_LEN)
            len_clamp = MIN_LEN;
        else if (bus.data_len > MAX_LEN)
            len_clamp = MAX_LEN;
        else
            len_clamp = bus.data_len;

        div_clamp = (bus.baud_div == '0) ? ONE : bus.baud_div;

        masked = '0;
        for (int i = 0; i < DATA_W; i++) begin
            masked[i] = bus.tx_data[i] & (4'(i) < len_clamp);
        end
        data_xor = ^masked;
    end

    assign accept  = bus.tx_valid & ready_q;
    assign bit_end = (cnt_q == ONE);

`ifdef UART_TX_BREAK_EN
    assign brk_entry = (state_q == S_IDLE) && !accept && send_break;
`else
    assign brk_entry = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            tx_out_q <= 1'b1;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            tx_out_q <= tx_out_d;
            ready_q  <= ready_d;
        end
    end

    // Shadow registers hold the frame's settings so inputs may change after accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            div_q    <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
        end else if (accept) begin
            len_q    <= len_clamp;
            div_q    <= div_clamp;
            par_en_q <= (bus.parity_type == 2'b01) || (bus.parity_type == 2'b10);
            par_q    <= (bus.parity_type == 2'b01) ? ~data_xor : data_xor;
            stop2_q  <= bus.stop_bits;
        end else if (brk_entry) begin
            div_q    <= div_clamp;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    cnt_d   = div_clamp;
                    bit_d   = '0;
                    sh_d    = masked;
                end
`ifdef UART_TX_BREAK_EN
                else if (send_break) begin
                    state_d = S_BRK;
                end
`endif
            end
            S_START, S_DATA, S_PARITY, S_STOP: begin
                if (!bit_end) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    cnt_d = div_q;
                    case (state_q)
                        S_START: begin
                            state_d = S_DATA;
                            bit_d   = '0;
                        end
                        S_DATA: begin
                            sh_d = sh_q >> 1;
                            if (bit_q == len_q - 4'd1) begin
                                state_d = par_en_q ? S_PARITY : S_STOP;
                                bit_d   = '0;
                            end else begin
                                bit_d = bit_q + 4'd1;
                            end
                        end
                        S_PARITY: begin
                            state_d = S_STOP;
                            bit_d   = '0;
                        end
                        default: begin
                            // bit_q counts completed stop bits
                            if (stop2_q && (bit_q == 4'd0)) begin
                                bit_d = 4'd1;
                            end else begin
                                state_d = S_IDLE;
                                bit_d   = '0;
                                cnt_d   = '0;
                            end
                        end
                    endcase
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BRK: begin
                if (!send_break) begin
                    state_d = S_BRK_END;
                    cnt_d   = div_q;
                end
            end
            S_BRK_END: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Line level and ready are registered from the next state to keep tx_out glitch-free
    always_comb begin
        tx_out_d   = 1'b1;
        ready_d    = (state_d == S_IDLE);
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_STOP) && bit_end && (!stop2_q || (bit_q == 4'd1));
        case (state_d)
            S_START:   tx_out_d = 1'b0;
            S_DATA:    tx_out_d = sh_d[0];
            S_PARITY:  tx_out_d = par_q;
`ifdef UART_TX_BREAK_EN
            S_BRK:     tx_out_d = 1'b0;
`endif
            default:   tx_out_d = 1'b1;
        endcase
    end

    assign tx_out       = tx_out_q;
    assign bus.tx_ready = ready_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - self-checking bench for uart_tx_framer against a bit-list frame model
module tb_uart_tx_framer;

    logic clk;
    logic rst_n;
    logic tx_out;
    logic busy;
    logic frame_done;
`ifdef UART_TX_BREAK_EN
    logic send_break;
`endif

    uart_tx_framer_if #(.DATA_W(9), .DIV_W(16)) bus_if ();

    uart_tx_framer #(.DATA_W(9), .DIV_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef UART_TX_BREAK_EN
        ,
        .send_break (send_break)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int fd_seen = 0;
    int fd_exp  = 0;
    bit exp_bits[$];

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_seen <= fd_seen + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Frame as a list of bit levels: start, clamped data LSB first, parity, stops
    task automatic model(input logic [8:0] d, input int len, input int par, input int stop);
        int n;
        int ones;
        n    = (len < 5) ? 5 : ((len > 9) ? 9 : len);
        ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_bits.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (par == 1) exp_bits.push_back((ones % 2) == 0);
        if (par == 2) exp_bits.push_back((ones % 2) == 1);
        exp_bits.push_back(1'b1);
        if (stop != 0) exp_bits.push_back(1'b1);
    endtask

    task automatic drive(input logic [8:0] d, input int len, input int par, input int stop,
                         input int div, input logic valid);
        bus_if.tx_data     = d;
        bus_if.data_len    = 4'(len);
        bus_if.parity_type = 2'(par);
        bus_if.stop_bits   = 1'(stop);
        bus_if.baud_div    = 16'(div);
        bus_if.tx_valid    = valid;
    endtask

    task automatic scramble(input logic valid);
        drive(9'($urandom), $urandom_range(0, 15), $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom_range(0, 7), valid);
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge
    task automatic start_frame(input logic [8:0] d, input int len, input int par,
                               input int stop, input int div);
        int guard;
        guard = 0;
        while (tx_ready_now() !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_b("ready before accept", bus_if.tx_ready, 1'b1);
        drive(d, len, par, stop, div, 1'b1);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic tx_ready_now();
        return bus_if.tx_ready;
    endfunction

    // Checks cycles 1..T of a frame starting at the current negedge, then the idle cycle after
    task automatic expect_frame(input logic [8:0] d, input int len, input int par,
                                input int stop, input int div, input string name);
        int dd;
        int t;
        model(d, len, par, stop);
        dd = (div == 0) ? 1 : div;
        t  = exp_bits.size() * dd;
        for (int k = 1; k <= t; k++) begin
            if (k > 1) @(negedge clk);
            check_b($sformatf("%s tx_out c%0d", name, k), tx_out, exp_bits[(k - 1) / dd]);
            check_b($sformatf("%s busy c%0d", name, k), busy, 1'b1);
            check_b($sformatf("%s frame_done c%0d", name, k), frame_done, k == t);
            check_b($sformatf("%s tx_ready c%0d", name, k), bus_if.tx_ready, 1'b0);
        end
        fd_exp++;
        @(negedge clk);
        check_b({name, " idle tx_out"}, tx_out, 1'b1);
        check_b({name, " idle tx_ready"}, bus_if.tx_ready, 1'b1);
        check_b({name, " idle busy"}, busy, 1'b0);
        check_b({name, " idle frame_done"}, frame_done, 1'b0);
    endtask

    task automatic one_frame(input logic [8:0] d, input int len, input int par,
                             input int stop, input int div, input string name);
        start_frame(d, len, par, stop, div);
        scramble(1'b0);
        expect_frame(d, len, par, stop, div, name);
    endtask

    initial begin
        logic [8:0] rd;
        int rl, rp, rs, rv;

        rst_n = 1'b0;
        drive('0, 8, 0, 0, 1, 1'b0);
`ifdef UART_TX_BREAK_EN
        send_break = 1'b0;
`endif
        #12;
        check_b("reset tx_out", tx_out, 1'b1);
        check_b("reset tx_ready", bus_if.tx_ready, 1'b0);
        check_b("reset busy", busy, 1'b0);
        check_b("reset frame_done", frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check_b("release tx_ready", bus_if.tx_ready, 1'b0);
        @(negedge clk);
        check_b("first cycle tx_ready", bus_if.tx_ready, 1'b1);

        one_frame(9'h0A5, 8, 0, 0, 4, "8N1 A5");
        one_frame(9'h041, 7, 2, 1, 2, "7E2 41");
        one_frame(9'h000, 8, 1, 0, 1, "8O1 00");
        one_frame(9'h01F, 3, 0, 0, 2, "len3 clamp");
        one_frame(9'h1FF, 15, 1, 0, 1, "len15 clamp");
        one_frame(9'h1E1, 5, 2, 0, 3, "5E1 high bits");
        one_frame(9'h12C, 9, 1, 1, 0, "9O2 div0");

        // Back-to-back: second word and different config presented right after first accept
        start_frame(9'h0C3, 8, 0, 0, 3);
        drive(9'h155, 9, 2, 1, 2, 1'b1);
        expect_frame(9'h0C3, 8, 0, 0, 3, "b2b first");
        @(posedge clk);
        @(negedge clk);
        scramble(1'b0);
        expect_frame(9'h155, 9, 2, 1, 2, "b2b second");

        // Reset during data bit 3 of an 8N1 div 3 frame
        start_frame(9'h0C3, 8, 0, 0, 3);
        scramble(1'b0);
        repeat (12) @(negedge clk);
        check_b("pre-reset data bit3", tx_out, 1'b0);
        rst_n = 1'b0;
        #1;
        check_b("mid reset tx_out", tx_out, 1'b1);
        check_b("mid reset busy", busy, 1'b0);
        check_b("mid reset frame_done", frame_done, 1'b0);
        check_b("mid reset tx_ready", bus_if.tx_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_b("post reset tx_ready", bus_if.tx_ready, 1'b1);
        check_b("post reset tx_out", tx_out, 1'b1);
        one_frame(9'h03C, 6, 1, 1, 2, "after reset");

`ifdef UART_TX_BREAK_EN
        drive('0, 8, 0, 0, 4, 1'b0);
        send_break = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) bus_if.baud_div = 16'd7;
            check_b($sformatf("break low c%0d", i), tx_out, 1'b0);
            check_b($sformatf("break ready c%0d", i), bus_if.tx_ready, 1'b0);
            check_b($sformatf("break busy c%0d", i), busy, 1'b1);
            if (i == 9) send_break = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_b($sformatf("break end high c%0d", i), tx_out, 1'b1);
            check_b($sformatf("break end ready c%0d", i), bus_if.tx_ready, 1'b0);
            check_b($sformatf("break end fd c%0d", i), frame_done, 1'b0);
        end
        @(negedge clk);
        check_b("after break ready", bus_if.tx_ready, 1'b1);
        check_b("after break busy", busy, 1'b0);
`endif

        for (int f = 0; f < 16; f++) begin
            rd = 9'($urandom);
            rl = $urandom_range(0, 15);
            rp = $urandom_range(0, 3);
            rs = $urandom_range(0, 1);
            rv = $urandom_range(0, 4);
            one_frame(rd, rl, rp, rs, rv, $sformatf("rand%0d", f));
        end

        @(negedge clk);
        #1;
        check_i("frame_done pulse count", fd_seen, fd_exp);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
Parametrised UART transmit framer and serializer. Accepts a data word over a valid/ready handshake and latches a per-frame configuration: data length, parity mode, stop-bit count and bit period. It then drives the serial line LSB-first as start, data, optional parity and 1 or 2 stop bits. Sits between the TX data source (register file or FIFO) and the tx pin.

Parameters:
DATA_W, 9, maximum data bits per frame; runtime length is clamped to 5..DATA_W; legal range 5..9.
DIV_W, 16, width of the bit-period divisor input.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
baud_div  input  DIV_W  clocks per bit; sampled on accept; 0 treated as 1.
data_len  input  4  data bits per frame; sampled on accept; <5 -> 5, >DATA_W -> DATA_W.
parity_type  input  2  00 none, 01 odd, 10 even, 11 none; sampled on accept.
stop_bits  input  1  0 = one stop bit, 1 = two; sampled on accept.
tx_data  input  DATA_W  word to send; bits above the clamped length ignored.
tx_valid  input  1  source has a word.
tx_ready  output  1  framer can accept (high only in IDLE).
tx_out  output  1  serial line, idle high.
busy  output  1  frame in progress (not IDLE).
frame_done  output  1  one-cycle pulse at end of last stop bit.

Behaviour:
- Reset (async, rst_n=0): tx_out=1, tx_ready=0 while asserted, busy=0, frame_done=0, state IDLE, all counters 0. tx_ready=1 from the first cycle after deassertion.
- Accept = tx_valid & tx_ready at a rising edge. Latches tx_data, clamped data_len, parity_type, stop_bits and baud_div (0->1) into shadow registers. Inputs may change freely afterwards.
- Parity is computed at accept over the clamped data bits only. Even: XOR of the bits (total ones including parity even). Odd: inverted XOR.
- States: IDLE -> START -> DATA -> (PARITY if type 01/10) -> STOP -> IDLE.
- tx_out is registered. Start bit (0) appears the cycle after accept.
- Each bit is held exactly D clocks (D = latched divisor) by a down-counter reloaded at every bit boundary.
- DATA shifts LSB first. The bit counter advances to the latched length, then moves to PARITY or STOP.
- STOP drives 1 for 1 or 2 bit periods.
- Total frame = (1 + N + P + S) x D clocks, measured from the cycle after accept.
- On the final clock of the last stop bit: frame_done=1 for one cycle and state returns to IDLE on that edge. tx_ready rises the following cycle, giving one idle-high clock between back-to-back frames.
- busy=1 from the cycle after accept through the last stop-bit cycle inclusive.
- tx_ready=0 and tx_valid ignored outside IDLE; no queueing.
- Reset mid-frame: line returns to 1 immediately. The frame is abandoned with no frame_done.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input send_break (1 bit).
- send_break sampled high in IDLE with no accept on that edge: enter BREAK. tx_out=0, tx_ready=0, busy=1 while send_break stays high.
- On deassert: hold tx_out=1 for one latched-divisor bit period (baud_div sampled on BREAK entry), then IDLE. No frame_done.
- If tx_valid and send_break are both high in IDLE, the data accept wins.
- Not defined: port absent, BREAK state not synthesised; behaviour otherwise identical.

Test Plan:
- 8N1, baud_div=4, tx_data=0xA5 -> tx_out 0,1,0,1,0,0,1,0,1,1 each for 4 clocks (40 clocks); frame_done pulses on clock 40; tx_ready high clock 41.
- 7E2, div=2, tx_data=0x41 -> start, data 1,0,0,0,0,0,1, parity 0, stop 1,1; 11 bits = 22 clocks.
- 8O1, div=1, tx_data=0x00 -> parity bit 1; data_len=3 with tx_data=0x1F sends exactly 5 data ones (clamped).
- tx_valid held high with two words, 8N1, div=3 -> frames back-to-back with exactly one idle-high clock; second frame uses config sampled at its own accept.
- rst_n low during data bit 3 -> tx_out=1 asynchronously, no frame_done, tx_ready=1 the cycle after release; next frame correct.
- (UART_TX_BREAK_EN) send_break high 10 clocks in IDLE, div=4 -> tx_out low 10 clocks, then high 4 clocks with tx_ready=0, then tx_ready=1.
